// File: rtl/pss_sequence_generator.sv
// pss_sequence_generator
// Generates one 127-sample NR PSS for the selected N_id_2 and streams it as
// BPSK-mapped {Q, I} samples over an AXI-stream master.
// Optional build macro: PSS_GEN_LUT_SEEK_EN -- replaces the stepped LFSR seek
// with a 3-entry table of pre-advanced LFSR states (offsets 0/43/86).
module pss_sequence_generator #(
  parameter int OUT_DW    = 32,
  parameter int AMPLITUDE = 8192,
  parameter int PSS_LEN   = 127
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              busy_o
);

  localparam int HW = OUT_DW / 2;
  localparam logic [HW-1:0] POS_I = HW'(AMPLITUDE);
  localparam logic [HW-1:0] NEG_I = HW'(-AMPLITUDE);
  localparam logic [6:0] LAST_IDX = 7'(PSS_LEN - 1);

  // LFSR bit k holds x(m+k); bit 0 is the current sample's x value.
  // Initial state x(6..0) = 1,1,1,0,1,1,0.
  localparam logic [6:0] LFSR_INIT = 7'b1110110;

  // One Fibonacci step: x(m+7) = x(m+4) xor x(m).
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[4] ^ s[0], s[6:1]};
  endfunction

  // BPSK map: x=0 -> d=+1 -> +A, x=1 -> d=-1 -> -A; Q is always zero.
  function automatic logic [OUT_DW-1:0] map_bit(input logic b);
    return {{HW{1'b0}}, (b ? NEG_I : POS_I)};
  endfunction

`ifdef PSS_GEN_LUT_SEEK_EN
  function automatic logic [6:0] lfsr_adv(input logic [6:0] s, input int n);
    logic [6:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = lfsr_step(t);
    return t;
  endfunction

  // Pre-advanced start states for N_id_2 = 0/1/2; entry 3 is never selected.
  localparam logic [6:0] SEED_LUT [0:3] = '{
    LFSR_INIT,
    lfsr_adv(LFSR_INIT, 43),
    lfsr_adv(LFSR_INIT, 86),
    LFSR_INIT
  };
`else
  logic [6:0] seek_cnt_q;
`endif

  typedef enum logic [1:0] {IDLE, SEEK, RUN} state_t;

  state_t            state_q;
  logic [6:0]        lfsr_q;
  logic [6:0]        cnt_q;
  logic [OUT_DW-1:0] tdata_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic              busy_q;
  logic [6:0]        lfsr_d;

  assign lfsr_d = lfsr_step(lfsr_q);

  // Sequencer FSM: all outputs registered, tready only gates state updates.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_INIT;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifndef PSS_GEN_LUT_SEEK_EN
      seek_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          lfsr_q <= LFSR_INIT;
          if (start_i && (N_id_2_i != 2'd3)) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            tlast_q <= 1'b0;
`ifdef PSS_GEN_LUT_SEEK_EN
            lfsr_q   <= SEED_LUT[N_id_2_i];
            tdata_q  <= map_bit(SEED_LUT[N_id_2_i][0]);
            tvalid_q <= 1'b1;
            state_q  <= RUN;
`else
            if (N_id_2_i == 2'd0) begin
              tdata_q  <= map_bit(LFSR_INIT[0]);
              tvalid_q <= 1'b1;
              state_q  <= RUN;
            end else begin
              // 43 or 86 steps; the counter ends at zero on the last step.
              seek_cnt_q <= (N_id_2_i == 2'd1) ? 7'd42 : 7'd85;
              state_q    <= SEEK;
            end
`endif
          end
        end

        SEEK: begin
`ifndef PSS_GEN_LUT_SEEK_EN
          lfsr_q <= lfsr_d;
          if (seek_cnt_q == 7'd0) begin
            tdata_q  <= map_bit(lfsr_d[0]);
            tvalid_q <= 1'b1;
            state_q  <= RUN;
          end else begin
            seek_cnt_q <= seek_cnt_q - 7'd1;
          end
`else
          state_q <= IDLE;
`endif
        end

        RUN: begin
          if (m_axis_out_tready) begin
            if (cnt_q == LAST_IDX) begin
              state_q  <= IDLE;
              lfsr_q   <= LFSR_INIT;
              cnt_q    <= '0;
              tdata_q  <= '0;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
            end else begin
              lfsr_q  <= lfsr_d;
              cnt_q   <= cnt_q + 7'd1;
              tdata_q <= map_bit(lfsr_d[0]);
              tlast_q <= (cnt_q == LAST_IDX - 7'd1);
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_pss_sequence_generator.sv
// Testbench for pss_sequence_generator: scoreboard of expected samples built
// from the PSS definition, checked by an independent output monitor.
module tb_pss_sequence_generator;
  localparam int OUT_DW = 32;
  localparam int A      = 8192;
  localparam int N      = 127;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        nid = 2'd0;
  logic [OUT_DW-1:0] tdata;
  logic              tvalid;
  logic              tready = 1'b1;
  logic              tlast;
  logic              busy;

  pss_sequence_generator #(.OUT_DW(OUT_DW), .AMPLITUDE(A), .PSS_LEN(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .N_id_2_i(nid),
    .m_axis_out_tdata(tdata), .m_axis_out_tvalid(tvalid),
    .m_axis_out_tready(tready), .m_axis_out_tlast(tlast), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [OUT_DW-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int xs [0:N-1];
  int done_cnt = 0;
  int xfer_idx = 0;
  int run_sum = 0;
  int last_sum = 0;
  int run_cap [0:N-1];
  int last_cap [0:N-1];
  bit bp_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: x sequence from the recurrence, then d(n)=1-2x((n+43N) mod 127).
  task automatic push_expected(input int n_id);
    exp_t e;
    int m;
    for (int i = 0; i < N; i++) begin
      m = (i + 43 * n_id) % N;
      e.d = {16'h0000, (xs[m] == 1) ? 16'(-A) : 16'(A)};
      e.l = (i == N - 1);
      exp_q.push_back(e);
    end
  endtask

  function automatic int exp_latency(input int n_id);
`ifdef PSS_GEN_LUT_SEEK_EN
    return 1 + 0 * n_id;
`else
    return 1 + 43 * n_id;
`endif
  endfunction

  // tready driver: always high, or 50% random when backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: sampled mid-cycle; a transfer happens at the next rising edge.
  bit stall_prev = 1'b0;
  logic [OUT_DW-1:0] hold_d;
  logic hold_l;
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_tdata", tdata, hold_d);
        chk("hold_tlast", tlast, hold_l);
      end
      stall_prev = tvalid && !tready;
      hold_d = tdata;
      hold_l = tlast;
      if (tvalid && tready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_xfer: got tdata %h with empty scoreboard", tdata);
        end else begin
          e = exp_q.pop_front();
          if (tdata !== e.d || tlast !== e.l) begin
            n_fail++;
            $display("FAIL sample[%0d]: got %h/%0b expected %h/%0b",
                     xfer_idx, tdata, tlast, e.d, e.l);
          end
        end
        if (xfer_idx < N) run_cap[xfer_idx] = int'($signed(tdata[15:0]));
        run_sum += int'($signed(tdata[15:0]));
        xfer_idx++;
        if (tlast) begin
          last_sum = run_sum;
          last_cap = run_cap;
          run_sum  = 0;
          xfer_idx = 0;
          done_cnt++;
        end
      end
    end
  end

  // Issue a start right now (caller is at posedge+1 in IDLE) and follow the run.
  task automatic run_seq(input int n_id, input bit poke);
    int lat;
    int guard;
    int d0;
    push_expected(n_id);
    d0 = done_cnt;
    nid = 2'(n_id);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 1;
    guard = 0;
    while (!tvalid && guard < 300) begin
      @(posedge clk); #1;
      lat++;
      guard++;
    end
    chk("first_valid_latency", lat, exp_latency(n_id));
    if (poke) begin
      repeat (20) @(posedge clk);
      #1;
      nid = 2'd2;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      chk("busy_during_poke", busy, 1);
      chk("valid_during_poke", tvalid, 1);
    end
    guard = 0;
    while (done_cnt == d0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("seq_done", done_cnt, d0 + 1);
    chk("valid_after_last", tvalid, 0);
    chk("busy_after_last", busy, 0);
  endtask

  int cap0 [0:N-1];
  int cap1 [0:N-1];
  int cap2 [0:N-1];
  int first7 [0:6];
  longint corr;
  int diffs;
  int guard;

  initial begin
    xs[0] = 0; xs[1] = 1; xs[2] = 1; xs[3] = 0; xs[4] = 1; xs[5] = 1; xs[6] = 1;
    for (int i = 0; i + 7 < N; i++) xs[i + 7] = (xs[i + 4] + xs[i]) % 2;
    first7 = '{A, -A, -A, A, -A, -A, -A};

    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;

    // Plain runs, tready held high.
    run_seq(0, 0);
    cap0 = last_cap;
    $display("seq N_id_2=0 done, sum I = %0d", last_sum);
    chk("sum_I_nid0", last_sum, -A);
    for (int i = 0; i < 7; i++) chk($sformatf("first7[%0d]", i), cap0[i], first7[i]);
    @(posedge clk); #1;
    run_seq(1, 0);
    cap1 = last_cap;
    $display("seq N_id_2=1 done");
    @(posedge clk); #1;
    run_seq(2, 0);
    cap2 = last_cap;
    $display("seq N_id_2=2 done");

    corr = 0;
    for (int i = 0; i < N; i++) corr += longint'(cap0[i]) * longint'(cap0[i]);
    chk("autocorr_peak", corr, longint'(N) * A * A);
    corr = 0;
    for (int i = 0; i < N; i++) corr += longint'(cap0[i]) * longint'(cap1[i]);
    chk("xcorr_01_below_peak", (corr < longint'(N) * A * A), 1);
    corr = 0;
    for (int i = 0; i < N; i++) corr += longint'(cap0[i]) * longint'(cap2[i]);
    chk("xcorr_02_below_peak", (corr < longint'(N) * A * A), 1);

    // Backpressure run with a start pulse during RUN.
    bp_en = 1'b1;
    @(posedge clk); #1;
    run_seq(1, 1);
    diffs = 0;
    for (int i = 0; i < N; i++) if (last_cap[i] != cap1[i]) diffs++;
    chk("bp_matches_ready_run", diffs, 0);
    $display("seq N_id_2=1 with backpressure and mid-run start done");

    // Invalid sector ID in IDLE is ignored.
    nid = 2'd3;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("nid3_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("nid3_valid_later", tvalid, 0);
    chk("nid3_busy_later", busy, 0);
    $display("start with N_id_2=3 ignored");

    // Reset in the middle of a sequence.
    push_expected(0);
    nid = 2'd0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    guard = 0;
    while (xfer_idx < 60 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reached_sample_60", (xfer_idx >= 60), 1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_valid", tvalid, 0);
    chk("mid_reset_busy", busy, 0);
    reset_i = 1'b0;
    exp_q.delete();
    xfer_idx = 0;
    run_sum = 0;
    $display("reset at sample 60 applied");
    bp_en = 1'b0;
    @(posedge clk); #1;
    run_seq(0, 0);
    chk("restart_first_sample", last_cap[0], A);
    $display("restart after reset done");

    // Back-to-back: second start in the idle cycle right after tlast.
    run_seq(1, 0);
    cap1 = last_cap;
    run_seq(1, 0);
    diffs = 0;
    for (int i = 0; i < N; i++) if (last_cap[i] != cap1[i]) diffs++;
    chk("back_to_back_identical", diffs, 0);
    $display("back-to-back N_id_2=1 pair done");

    // A few random sectors under random backpressure.
    bp_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      int n_id;
      n_id = int'($urandom_range(0, 2));
      @(posedge clk); #1;
      run_seq(n_id, 0);
      $display("random run %0d N_id_2=%0d done", r, n_id);
    end
    bp_en = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("idle_valid_end", tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
